// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM arbiter: FSM encoding, port indices and
// default RAM geometry.
package ram_ctrl_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_ADDR_WIDTH = 10;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_LS = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin select: a lone requester wins, under contention the
// port that did not win last time is chosen.
module rr_pick2
   import ram_ctrl_pkg::*;
(
   input  logic       req0_i,
   input  logic       req1_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      if (req0_i && req1_i) begin
         gnt_o = (last_i == PORT_LS) ? 2'b01 : 2'b10;
      end else begin
         gnt_o = {req1_i, req0_i};
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter and access sequencer sharing one single-port synchronous RAM between
// the instruction-fetch port (0) and the load/store port (1).
module ram_arbiter
   import ram_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  done0,
   output logic                  done1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  busy,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic                  ram_oe,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   arb_state_e            state_q, state_d;
   logic                  last_q, last_d;
   logic                  opWe_q, opWe_d;
   logic                  opPort_q, opPort_d;
   logic                  ramCs_q, ramCs_d;
   logic                  ramWe_q, ramWe_d;
   logic                  ramOe_q, ramOe_d;
   logic [ADDR_WIDTH-1:0] ramAddr_q, ramAddr_d;
   logic [DATA_WIDTH-1:0] ramWdata_q, ramWdata_d;
   logic                  done0_q, done0_d;
   logic                  done1_q, done1_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
   logic [1:0]            pick;

   rr_pick2 u_pick (
      .req0_i (req0),
      .req1_i (req1),
      .last_i (last_q),
      .gnt_o  (pick)
   );

   // RAM controls are computed one state ahead so the registered outputs line
   // up with ACCESS/RESP; RESP keeps oe high so the RAM output stays driven.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      opWe_d     = opWe_q;
      opPort_d   = opPort_q;
      ramCs_d    = 1'b0;
      ramWe_d    = 1'b0;
      ramOe_d    = 1'b0;
      ramAddr_d  = ramAddr_q;
      ramWdata_d = ramWdata_q;
      done0_d    = 1'b0;
      done1_d    = 1'b0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (rst_n && (pick != 2'b00)) begin
               gnt0       = pick[0];
               gnt1       = pick[1];
               opPort_d   = pick[1];
               last_d     = pick[1];
               opWe_d     = pick[1] ? we1 : we0;
               ramAddr_d  = pick[1] ? addr1 : addr0;
               ramWdata_d = pick[1] ? wdata1 : wdata0;
               ramCs_d    = 1'b1;
               ramWe_d    = opWe_d;
               ramOe_d    = !opWe_d;
               state_d    = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (opWe_q) begin
               done0_d = (opPort_q == PORT_IF);
               done1_d = (opPort_q == PORT_LS);
               state_d = ST_IDLE;
            end else begin
               ramCs_d = 1'b1;
               ramOe_d = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            done0_d = (opPort_q == PORT_IF);
            done1_d = (opPort_q == PORT_LS);
            if (opPort_q == PORT_LS) begin
               rdata1_d = ram_rdata;
            end else begin
               rdata0_d = ram_rdata;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         last_q     <= PORT_LS;
         opWe_q     <= 1'b0;
         opPort_q   <= PORT_IF;
         ramCs_q    <= 1'b0;
         ramWe_q    <= 1'b0;
         ramOe_q    <= 1'b0;
         ramAddr_q  <= '0;
         ramWdata_q <= '0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         opWe_q     <= opWe_d;
         opPort_q   <= opPort_d;
         ramCs_q    <= ramCs_d;
         ramWe_q    <= ramWe_d;
         ramOe_q    <= ramOe_d;
         ramAddr_q  <= ramAddr_d;
         ramWdata_q <= ramWdata_d;
         done0_q    <= done0_d;
         done1_q    <= done1_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done0     = done0_q;
   assign done1     = done1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign ram_cs    = ramCs_q;
   assign ram_we    = ramWe_q;
   assign ram_oe    = ramOe_q;
   assign ram_addr  = ramAddr_q;
   assign ram_wdata = ramWdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: grants push expected responses, a monitor
// pops them on each done pulse; directed phases cover reset, contention and writes.
module tb_ram_arbiter;

   localparam int DW = 32;
   localparam int AW = 10;

   logic          clk;
   logic          rst_n;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, done0, done1, busy;
   logic [DW-1:0] rdata0, rdata1;
   logic          ram_cs, ram_we, ram_oe;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;

   ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural basic_ram: registered read, output driven only on cs & oe & !we.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] ramOut = '0;
   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_we) mem[ram_addr] = ram_wdata;
         else        ramOut <= mem[ram_addr];
      end
   end
   assign ram_rdata = (ram_cs && ram_oe && !ram_we) ? ramOut : '0;

   typedef struct {
      int            grantCycle;
      bit            isRead;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          expQ0[$];
   exp_t          expQ1[$];
   exp_t          e;
   int            grantSeq[$];
   logic [DW-1:0] shadow [0:(1<<AW)-1];
   int            cycle = 0;
   int            checks = 0;
   int            errors = 0;
   int            grants1 = 0;
   bit            accPending = 0;
   logic [AW-1:0] accAddr;
   bit            accWe;
   logic [DW-1:0] accWdata;
   logic [DW-1:0] prevRdata0 = '0;
   logic [DW-1:0] prevRdata1 = '0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Monitor and scoreboard: completions are popped before new grants are pushed.
   always @(negedge clk) begin
      if (!rst_n) begin
         expQ0.delete();
         expQ1.delete();
         accPending = 0;
      end else begin
         if (accPending) begin
            checkOutput("ram_cs in ACCESS", ram_cs, 1);
            checkOutput("ram_addr", ram_addr, accAddr);
            checkOutput("ram_we", ram_we, accWe);
            checkOutput("ram_oe", ram_oe, !accWe);
            if (accWe) checkOutput("ram_wdata", ram_wdata, accWdata);
            accPending = 0;
         end
         if (done0) begin
            if (expQ0.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL done0: pulse with no pending access");
            end else begin
               e = expQ0.pop_front();
               checkOutput("done0 latency", 32'(cycle - e.grantCycle), e.isRead ? 32'd3 : 32'd2);
               if (e.isRead) checkOutput("rdata0", rdata0, e.data);
               checkOutput("rdata1 untouched", rdata1, prevRdata1);
            end
         end
         if (done1) begin
            if (expQ1.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL done1: pulse with no pending access");
            end else begin
               e = expQ1.pop_front();
               checkOutput("done1 latency", 32'(cycle - e.grantCycle), e.isRead ? 32'd3 : 32'd2);
               if (e.isRead) checkOutput("rdata1", rdata1, e.data);
               checkOutput("rdata0 untouched", rdata0, prevRdata0);
            end
         end
         if (gnt0 && gnt1) begin
            checks++; errors++;
            $display("[TB] FAIL gnt onehot: both grants high");
         end else if (gnt0 || gnt1) begin
            accAddr    = gnt1 ? addr1 : addr0;
            accWe      = gnt1 ? we1 : we0;
            accWdata   = gnt1 ? wdata1 : wdata0;
            accPending = 1;
            e.grantCycle = cycle;
            e.isRead     = !accWe;
            e.data       = accWe ? accWdata : shadow[accAddr];
            if (accWe) shadow[accAddr] = accWdata;
            if (gnt1) begin
               expQ1.push_back(e);
               grants1++;
            end else begin
               expQ0.push_back(e);
            end
            grantSeq.push_back(gnt1 ? 1 : 0);
         end
      end
      prevRdata0 = rdata0;
      prevRdata1 = rdata1;
   end

   // Called just after a rising edge; returns just after the edge that follows the grant.
   task automatic applyStimulus(input int port, input bit we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, output int gc, output bit doneAtGnt);
      bit got = 0;
      gc = -1;
      doneAtGnt = 0;
      if (port == 0) begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wdata; end
      else           begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wdata; end
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if ((port == 0) ? gnt0 : gnt1) begin
            got = 1;
            gc = cycle;
            doneAtGnt = (port == 0) ? done0 : done1;
         end
      end
      if (!got) begin
         checks++; errors++;
         $display("[TB] FAIL grant timeout: port %0d got no grant, want one within 20 cycles", port);
      end
      @(posedge clk);
      #1;
      if (port == 0) req0 = 0; else req1 = 0;
   endtask

   task automatic waitIdle();
      bit ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (!busy && !done0 && !done1 && expQ0.size() == 0 && expQ1.size() == 0) ok = 1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("[TB] FAIL idle timeout: busy=%0d pending=%0d, want idle", busy, expQ0.size() + expQ1.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   int  gA, gB;
   bit  dA, dB;
   bit  sawDone;
   int  g1Before;

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i]    = 32'hA500_0000 | i;
         shadow[i] = 32'hA500_0000 | i;
      end
      rst_n = 0;
      req0 = 1; we0 = 0; addr0 = 10'h001; wdata0 = '0;
      req1 = 1; we1 = 0; addr1 = 10'h002; wdata1 = '0;

      // Reset with both requests pending
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset gnt0", gnt0, 0);
      checkOutput("reset gnt1", gnt1, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done0", done0, 0);
      checkOutput("reset done1", done1, 0);
      checkOutput("reset ram_cs", ram_cs, 0);
      checkOutput("reset ram_we", ram_we, 0);
      checkOutput("reset ram_oe", ram_oe, 0);
      checkOutput("reset ram_addr", ram_addr, 0);
      checkOutput("reset ram_wdata", ram_wdata, 0);
      checkOutput("reset rdata0", rdata0, 0);
      checkOutput("reset rdata1", rdata1, 0);
      @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      checkOutput("first cycle gnt0", gnt0, 1);
      checkOutput("first cycle gnt1", gnt1, 0);

      // Contention: both ports keep reading for 12 cycles
      repeat (12) @(posedge clk);
      #1;
      req0 = 0;
      req1 = 0;
      waitIdle();
      checkOutput("contention grant count", grantSeq.size(), 4);
      for (int i = 0; i < 4 && i < grantSeq.size(); i++)
         checkOutput($sformatf("grant order %0d", i), grantSeq[i], i % 2);
      checkOutput("contention rdata0", rdata0, 32'hA500_0001);
      checkOutput("contention rdata1", rdata1, 32'hA500_0002);

      // Port 0 write then read-back of 0x005
      applyStimulus(0, 1, 10'h005, 32'hDEAD_BEEF, gA, dA);
      applyStimulus(0, 0, 10'h005, 32'h0, gB, dB);
      checkOutput("write-read grant gap", 32'(gB - gA), 2);
      waitIdle();
      checkOutput("readback 0x005", rdata0, 32'hDEAD_BEEF);

      // Port 1 back-to-back writes at the address extremes
      applyStimulus(1, 1, 10'h3FF, 32'hCAFE_F00D, gA, dA);
      applyStimulus(1, 1, 10'h000, 32'h1234_5678, gB, dB);
      checkOutput("write-write grant gap", 32'(gB - gA), 2);
      checkOutput("done1 with second gnt1", dB, 1);
      waitIdle();
      applyStimulus(0, 0, 10'h3FF, 32'h0, gA, dA);
      waitIdle();
      checkOutput("readback 0x3FF", rdata0, 32'hCAFE_F00D);
      applyStimulus(1, 0, 10'h000, 32'h0, gA, dA);
      waitIdle();
      checkOutput("readback 0x000", rdata1, 32'h1234_5678);

      // Reset while a read is in RESP
      applyStimulus(0, 0, 10'h005, 32'h0, gA, dA);
      @(posedge clk);
      #1;
      checkOutput("RESP ram_oe", ram_oe, 1);
      rst_n = 0;
      sawDone = 0;
      repeat (3) begin
         @(negedge clk);
         if (done0) sawDone = 1;
      end
      @(posedge clk);
      #1 rst_n = 1;
      repeat (3) begin
         @(negedge clk);
         if (done0) sawDone = 1;
      end
      checkOutput("no done0 after reset in RESP", sawDone, 0);
      checkOutput("rdata0 cleared", rdata0, 0);
      checkOutput("busy after reset", busy, 0);
      @(posedge clk);
      #1;
      applyStimulus(0, 0, 10'h005, 32'h0, gA, dA);
      waitIdle();
      checkOutput("read after reset", rdata0, 32'hDEAD_BEEF);

      // Port 1 raises and withdraws a request while port 0 is busy
      g1Before = grants1;
      applyStimulus(0, 0, 10'h001, 32'h0, gA, dA);
      req1 = 1; we1 = 1; addr1 = 10'h007; wdata1 = 32'hBAD0_BAD0;
      @(posedge clk);
      #1 req1 = 0;
      waitIdle();
      checkOutput("withdrawn gnt1 count", grants1 - g1Before, 0);
      checkOutput("withdrawn no write", mem[7], 32'hA500_0007);

      checkOutput("pending responses", expQ0.size() + expQ1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and sequencer for the single-port synchronous 32-bit RAM (`basic_ram`). Shares the RAM between the instruction-fetch port (port 0) and the load/store port (port 1) of the ARMv4 core. Sequences each access to meet the RAM's timing: a one-cycle registered read, plus a data output that is driven only while cs, oe and !we are all high. Grants alternate round-robin under contention.

## Interface
Parameters:
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 10, RAM word-address width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req0 / req1  in  1  access request from port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read; valid while the request is high
- addr0 / addr1  in  ADDR_WIDTH  word address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- gnt0 / gnt1  out  1  request accepted this cycle; combinational; one-cycle pulse
- done0 / done1  out  1  access complete; registered; one-cycle pulse
- rdata0 / rdata1  out  DATA_WIDTH  read data; valid while doneN=1 after a read; otherwise holds its last value
- busy  out  1  FSM not in IDLE
- ram_cs, ram_we, ram_oe  out  1  RAM controls, registered
- ram_addr  out  ADDR_WIDTH  RAM address, registered
- ram_wdata  out  DATA_WIDTH  RAM write data, registered
- ram_rdata  in  DATA_WIDTH  RAM data_output

## Operation
FSM states are IDLE, ACCESS and RESP.

IDLE:
- ram_cs, ram_we and ram_oe are all 0.
- If any reqN is high, select a winner. A lone requester wins. If both request, the winner is the port not in `last`.
- Assert gntN for the winner in that cycle.
- At the edge: latch addrN, weN and wdataN into the ram_* registers and into op_we/op_port, set `last` to N, and go to ACCESS.

ACCESS:
- ram_cs=1, ram_we=op_we, ram_oe=!op_we.
- At the edge, the RAM writes or loads its output register.
- Write: go to IDLE and set done[op_port]=1 for the next cycle.
- Read: go to RESP.

RESP:
- ram_cs=1, ram_oe=1, ram_we=0, and the address is held. This keeps the RAM output enabled.
- The RAM re-reads the same address, which has no side effect.
- At the edge: rdata[op_port] ← ram_rdata, done[op_port]=1 for the next cycle, go to IDLE.

Handshake and state rules:
- A requester holds reqN, weN, addrN and wdataN stable until the edge at which gntN=1.
- A requester may drop reqN at any time before that edge. This has no side effect.
- After the grant, a new request from the same port is accepted only after that port's doneN pulse. The port is allowed to hold req high; it is simply not sampled while busy.
- `last` resets to 1, so port 0 wins the first contention.
- The done pulse and a new grant may coincide: IDLE accepts in the same cycle doneN is high.
- The arbiter does no address arithmetic. Addresses pass unchanged. There is no wrap handling and no bounds check.
- rdata for the other port is untouched by an access.

## Timing
- Read: accepted at edge E0 → ACCESS during E0–E1 → RESP during E1–E2 → doneN=1 and rdataN valid in the cycle after E2. Latency is 3 cycles from the grant cycle.
- Write: accepted at E0 → ACCESS → doneN in the cycle after E1. The memory is updated at E1.
- Back-to-back throughput: 1 read per 3 cycles, 1 write per 2 cycles.
- Reset (rst_n=0, any time):
  - state → IDLE, `last` → 1
  - all ram_*, doneN, rdataN → 0
  - gntN = 0 while in reset
  - busy = 0
- Reset mid-operation:
  - In ACCESS: the write is not guaranteed; it is complete only if E1 preceded the reset. No done pulse is generated.
  - In RESP: the read data is discarded.
- After rst_n rises, the first grant is possible in the first cycle.

## Structure
- Shared package `ram_ctrl_pkg` holds:
  - the FSM state encoding (IDLE, ACCESS, RESP)
  - the port index constants (PORT_IF=0, PORT_LS=1)
  - the default DATA_WIDTH and ADDR_WIDTH
- Sub-module `rr_pick2`: combinational two-way round-robin select. Inputs are req0, req1 and last; outputs are the one-hot grant. It is instantiated once.
- The FSM, latches and output registers live in ram_arbiter.

## Test plan
- Reset: hold rst_n=0 with both reqs high → all outputs 0, no gnt. Release → gnt0=1 in the first cycle.
- Port 0 writes 0xDEADBEEF to 0x005, then reads 0x005 → done0 two cycles after the write grant. Read: rdata0=0xDEADBEEF with done0 three cycles after the grant.
- Both ports request reads of 0x001 and 0x002 every cycle for 12 cycles → grants alternate 0,1,0,1. Each done arrives 3 cycles after its gnt. rdata1 never changes on port-0 completions.
- Back-to-back writes from port 1 at 0x3FF and 0x000 → ram_addr carries 0x3FF then 0x000 unchanged. Grants are 2 cycles apart. The second gnt1 coincides with the first done1.
- Read in flight: drop rst_n in RESP → done0 never asserts, rdata0=0, state IDLE. A subsequent read completes normally.
- Withdrawal: req1 raised for one cycle while busy, then dropped → no gnt1, no done1, no RAM access for port 1.
